// File: rtl/sid_write_sched.sv
// sid_write_sched: paces and arbitrates SID register writes from two buffered
// requesters (A = SPI host stream, B = register-dump player).
// Ports:
//   CLK, RST          12 MHz clock, asynchronous active-high reset
//   CLKen             1 MHz SID tick, one CLK wide
//   A_VALID/A_READY   port A request / FIFO not full; A_ADDR, A_DATA payload
//   B_VALID/B_READY   port B request / FIFO not full; B_ADDR, B_DATA payload
//   WR                one-CLK write strobe to the SID
//   ADDR, DATAW       last issued address/data, held until the next issue
//   GRANT             port of the last issued write (0 = A, 1 = B)
//   BUSY              a FIFO holds data or a write is being issued
module sid_write_sched #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MIN_GAP = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLKen,
    input  logic       A_VALID,
    output logic       A_READY,
    input  logic [4:0] A_ADDR,
    input  logic [7:0] A_DATA,
    input  logic       B_VALID,
    output logic       B_READY,
    input  logic [4:0] B_ADDR,
    input  logic [7:0] B_DATA,
    output logic       WR,
    output logic [4:0] ADDR,
    output logic [7:0] DATAW,
    output logic       GRANT,
    output logic       BUSY
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 13;
    localparam int unsigned GW = 8;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t        state;
    logic [EW-1:0] mem_a [DEPTH];
    logic [EW-1:0] mem_b [DEPTH];
    logic [PW-1:0] wp_a, rp_a, wp_b, rp_b;
    logic [PW-1:0] wp_a_nxt, rp_a_nxt, wp_b_nxt, rp_b_nxt;
    logic [GW-1:0] gap;
    logic          empty_a, empty_b;
    logic          push_a, push_b, pop_a, pop_b;
    logic          pick, sel_b;
    logic [EW-1:0] head;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    function automatic logic is_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return (wp[PW-1] != rp[PW-1]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    // Selection, pop/push qualification and next pointers.
    always_comb begin
        empty_a  = (wp_a == rp_a);
        empty_b  = (wp_b == rp_b);
        // READY is a registered !full, so a full FIFO refuses even while popped.
        push_a   = A_VALID && A_READY;
        push_b   = B_VALID && B_READY;
        pick     = (state == IDLE) && CLKen && (gap == '0) && (!empty_a || !empty_b);
        // Lone non-empty port wins; on a tie the port that did not go last wins.
        sel_b    = empty_a || (!empty_b && !GRANT);
        pop_a    = pick && !sel_b;
        pop_b    = pick && sel_b;
        wp_a_nxt = push_a ? wp_a + PW'(1) : wp_a;
        rp_a_nxt = pop_a  ? rp_a + PW'(1) : rp_a;
        wp_b_nxt = push_b ? wp_b + PW'(1) : wp_b;
        rp_b_nxt = pop_b  ? rp_b + PW'(1) : rp_b;
        head     = sel_b ? mem_b[rp_b[AW-1:0]] : mem_a[rp_a[AW-1:0]];
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (push_a) mem_a[wp_a[AW-1:0]] <= {A_ADDR, A_DATA};
        if (push_b) mem_b[wp_b[AW-1:0]] <= {B_ADDR, B_DATA};
    end

    // Scheduler FSM, pointers, gap counter and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            WR      <= 1'b0;
            ADDR    <= '0;
            DATAW   <= '0;
            GRANT   <= 1'b1;
            BUSY    <= 1'b0;
            A_READY <= 1'b1;
            B_READY <= 1'b1;
            gap     <= '0;
            wp_a    <= '0;
            rp_a    <= '0;
            wp_b    <= '0;
            rp_b    <= '0;
        end else begin
            wp_a    <= wp_a_nxt;
            rp_a    <= rp_a_nxt;
            wp_b    <= wp_b_nxt;
            rp_b    <= rp_b_nxt;
            A_READY <= !is_full(wp_a_nxt, rp_a_nxt);
            B_READY <= !is_full(wp_b_nxt, rp_b_nxt);
            BUSY    <= (wp_a_nxt != rp_a_nxt) || (wp_b_nxt != rp_b_nxt) || pick;
            // Ticks keep counting down in either state; a new issue reloads.
            if (CLKen && (gap != '0)) gap <= gap - GW'(1);
            case (state)
                IDLE: begin
                    WR <= 1'b0;
                    if (pick) begin
                        state <= ISSUE;
                        WR    <= 1'b1;
                        ADDR  <= head[EW-1:8];
                        DATAW <= head[7:0];
                        GRANT <= sel_b;
                        gap   <= GW'(MIN_GAP - 1);
                    end
                end
                ISSUE: begin
                    state <= IDLE;
                    WR    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    WR    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sid_write_sched.sv
// tb_sid_write_sched: checks two schedulers (MIN_GAP=1 and MIN_GAP=3) driven by
// the same stimulus against a queue-based reference model of the write rules.
module tb_sid_write_sched;

    localparam int DEPTH = 4;

    typedef logic [12:0] ent_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CLKen;
    logic       A_VALID, B_VALID;
    logic [4:0] A_ADDR, B_ADDR;
    logic [7:0] A_DATA, B_DATA;

    logic       a_ready [2];
    logic       b_ready [2];
    logic       wr      [2];
    logic [4:0] addr    [2];
    logic [7:0] dataw   [2];
    logic       grant   [2];
    logic       busy    [2];

    int nvec = 0;
    int nmis = 0;
    int ccnt = 0;
    bit ck_on = 0;
    bit ck_rand = 0;

    // Reference model state, one slot per DUT.
    ent_t       mqa [2][$];
    ent_t       mqb [2][$];
    int         mgap   [2];
    bit         missue [2];
    logic       mwr    [2];
    logic [4:0] maddr  [2];
    logic [7:0] mdata  [2];
    logic       mgrant [2];

    always #5 CLK = ~CLK;

    sid_write_sched #(.DEPTH(DEPTH), .MIN_GAP(1)) dut0 (
        .CLK(CLK), .RST(RST), .CLKen(CLKen),
        .A_VALID(A_VALID), .A_READY(a_ready[0]), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(b_ready[0]), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
        .WR(wr[0]), .ADDR(addr[0]), .DATAW(dataw[0]), .GRANT(grant[0]), .BUSY(busy[0])
    );

    sid_write_sched #(.DEPTH(DEPTH), .MIN_GAP(3)) dut1 (
        .CLK(CLK), .RST(RST), .CLKen(CLKen),
        .A_VALID(A_VALID), .A_READY(a_ready[1]), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(b_ready[1]), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
        .WR(wr[1]), .ADDR(addr[1]), .DATAW(dataw[1]), .GRANT(grant[1]), .BUSY(busy[1])
    );

    function automatic int gapv(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mqa[k].delete();
            mqb[k].delete();
            mgap[k]   = 0;
            missue[k] = 0;
            mwr[k]    = 1'b0;
            maddr[k]  = '0;
            mdata[k]  = '0;
            mgrant[k] = 1'b1;
        end
    endtask

    // One clock edge of the write rules, using the inputs held before the edge.
    task automatic model_step();
        bit   ra, rb, selb;
        ent_t e;
        for (int k = 0; k < 2; k++) begin
            ra = (mqa[k].size() < DEPTH);
            rb = (mqb[k].size() < DEPTH);
            if (!missue[k] && CLKen && mgap[k] == 0 && (mqa[k].size() + mqb[k].size()) > 0) begin
                if (mqa[k].size() == 0)      selb = 1;
                else if (mqb[k].size() == 0) selb = 0;
                else                         selb = !mgrant[k];
                e = selb ? mqb[k].pop_front() : mqa[k].pop_front();
                mwr[k]    = 1'b1;
                maddr[k]  = e[12:8];
                mdata[k]  = e[7:0];
                mgrant[k] = selb;
                mgap[k]   = gapv(k) - 1;
                missue[k] = 1;
            end else begin
                mwr[k]    = 1'b0;
                missue[k] = 0;
                if (CLKen && mgap[k] > 0) mgap[k]--;
            end
            if (A_VALID && ra) mqa[k].push_back({A_ADDR, A_DATA});
            if (B_VALID && rb) mqb[k].push_back({B_ADDR, B_DATA});
        end
    endtask

    function automatic logic [17:0] obs(input int k);
        return {wr[k], addr[k], dataw[k], grant[k], busy[k], a_ready[k], b_ready[k]};
    endfunction

    function automatic logic [17:0] expv(input int k);
        logic bz, ra, rb;
        bz = (mqa[k].size() != 0) || (mqb[k].size() != 0) || missue[k];
        ra = (mqa[k].size() < DEPTH);
        rb = (mqb[k].size() < DEPTH);
        return {mwr[k], maddr[k], mdata[k], mgrant[k], bz, ra, rb};
    endfunction

    // Drive CLKen for the coming cycle, clock once, land on the falling edge.
    task automatic advance();
        if (ck_rand) CLKen = ($urandom_range(0, 3) == 0);
        else         CLKen = ck_on && (ccnt == 11);
        ccnt = (ccnt == 11) ? 0 : ccnt + 1;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        A_VALID = 0; B_VALID = 0; CLKen = 0;
        A_ADDR = '0; A_DATA = '0; B_ADDR = '0; B_DATA = '0;
        ck_on = 0; ck_rand = 0;
        RST = 1;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 0;
        ccnt = 0;
    endtask

    task automatic test_reset();
        logic [17:0] rv;
        rv = 18'b0_00000_00000000_1_0_1_1;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs(k) !== rv) begin
                nmis++;
                $display("FAIL reset_val dut%0d got %h want %h", k, obs(k), rv);
            end
        end
        advance();
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs(k) !== expv(k) || obs(k) !== rv) begin
                nmis++;
                $display("FAIL reset_idle dut%0d got %h want %h", k, obs(k), rv);
            end
        end
    endtask

    task automatic test_single();
        int first_ck, wr_at, pulses;
        logic [13:0] last;
        first_ck = -1; wr_at = -1; pulses = 0; last = '0;
        do_reset();
        ck_on = 1;
        A_VALID = 1; A_ADDR = 5'h18; A_DATA = 8'h0F;
        advance();
        A_VALID = 0;
        for (int i = 0; i < 40; i++) begin
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL single dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
            if (CLKen && first_ck < 0) first_ck = i;
            if (wr[0]) begin
                pulses++;
                last = {grant[0], addr[0], dataw[0]};
                if (wr_at < 0) wr_at = i;
            end
        end
        nvec++;
        if (pulses !== 1 || last !== {1'b0, 5'h18, 8'h0F}) begin
            nmis++;
            $display("FAIL single_pulse got n=%0d %h want n=1 %h", pulses, last, {1'b0, 5'h18, 8'h0F});
        end
        nvec++;
        if (wr_at !== first_ck) begin
            nmis++;
            $display("FAIL single_latency got wr@%0d want wr@%0d", wr_at, first_ck);
        end
    endtask

    task automatic test_round_robin();
        logic [13:0] got [$];
        logic [13:0] want [4];
        int pit [$];
        want[0] = {1'b0, 5'h00, 8'h11};
        want[1] = {1'b1, 5'h02, 8'h33};
        want[2] = {1'b0, 5'h01, 8'h22};
        want[3] = {1'b1, 5'h03, 8'h44};
        do_reset();
        A_VALID = 1; B_VALID = 1;
        A_ADDR = 5'h00; A_DATA = 8'h11; B_ADDR = 5'h02; B_DATA = 8'h33;
        advance();
        A_ADDR = 5'h01; A_DATA = 8'h22; B_ADDR = 5'h03; B_DATA = 8'h44;
        advance();
        A_VALID = 0; B_VALID = 0;
        ck_on = 1;
        for (int i = 0; i < 130; i++) begin
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL rr dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
            if (wr[0]) begin
                got.push_back({grant[0], addr[0], dataw[0]});
                pit.push_back(i);
            end
        end
        nvec++;
        if (got.size() != 4) begin
            nmis++;
            $display("FAIL rr_count got %0d want 4", got.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                nvec++;
                if (got[j] !== want[j]) begin
                    nmis++;
                    $display("FAIL rr_order[%0d] got %h want %h", j, got[j], want[j]);
                end
                if (j > 0) begin
                    nvec++;
                    if (pit[j] - pit[j-1] != 12) begin
                        nmis++;
                        $display("FAIL rr_spacing[%0d] got %0d want 12", j, pit[j] - pit[j-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_gap();
        int pit [$];
        do_reset();
        A_VALID = 1;
        for (int i = 0; i < 3; i++) begin
            A_ADDR = 5'(i + 4); A_DATA = 8'($urandom);
            advance();
        end
        A_VALID = 0;
        ck_on = 1;
        for (int i = 0; i < 120; i++) begin
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL gap dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
            if (wr[1]) pit.push_back(i);
        end
        nvec++;
        if (pit.size() != 3) begin
            nmis++;
            $display("FAIL gap_count got %0d want 3", pit.size());
        end else begin
            for (int j = 1; j < 3; j++) begin
                nvec++;
                if (pit[j] - pit[j-1] != 36) begin
                    nmis++;
                    $display("FAIL gap_spacing[%0d] got %0d want 36", j, pit[j] - pit[j-1]);
                end
            end
        end
    endtask

    task automatic test_full();
        ent_t acc [$];
        ent_t got [$];
        ent_t cur;
        bit   took;
        do_reset();
        A_VALID = 1;
        cur = {5'h01, 8'($urandom)};
        for (int i = 0; i < 6; i++) begin
            A_ADDR = cur[12:8]; A_DATA = cur[7:0];
            took = a_ready[0];
            if (took) acc.push_back(cur);
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL full_fill dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
            if (took) cur = {5'(i + 2), 8'($urandom)};
        end
        nvec++;
        if (acc.size() != DEPTH || a_ready[0] !== 1'b0) begin
            nmis++;
            $display("FAIL full_accepts got n=%0d rdy=%b want n=%0d rdy=0", acc.size(), a_ready[0], DEPTH);
        end
        A_VALID = 0;
        ck_on = 1;
        for (int i = 0; i < 130; i++) begin
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL full_drain dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
            if (wr[0]) got.push_back({addr[0], dataw[0]});
        end
        nvec++;
        if (got != acc) begin
            nmis++;
            $display("FAIL full_order got n=%0d want n=%0d", got.size(), acc.size());
        end
    endtask

    task automatic test_full_pop();
        ent_t acc [$];
        ent_t got [$];
        bit   seen, rdy_before;
        seen = 0;
        do_reset();
        A_VALID = 1;
        for (int i = 0; i < DEPTH; i++) begin
            A_ADDR = 5'(i + 8); A_DATA = 8'($urandom);
            acc.push_back({A_ADDR, A_DATA});
            advance();
        end
        A_ADDR = 5'h1F; A_DATA = 8'($urandom);
        ck_on = 1;
        rdy_before = 1;
        for (int i = 0; i < 30 && !seen; i++) begin
            rdy_before = a_ready[0];
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL fpop dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
            if (wr[0]) begin
                seen = 1;
                got.push_back({addr[0], dataw[0]});
            end
        end
        nvec++;
        if (!seen) begin
            nmis++;
            $display("FAIL fpop_timeout got no WR want WR within 30 cycles");
        end else if (rdy_before !== 1'b0 || a_ready[0] !== 1'b1) begin
            nmis++;
            $display("FAIL fpop_refuse got rdy %b->%b want 0->1", rdy_before, a_ready[0]);
        end
        acc.push_back({A_ADDR, A_DATA});
        advance();
        nvec++;
        if (a_ready[0] !== 1'b0) begin
            nmis++;
            $display("FAIL fpop_accept got rdy=%b want 0", a_ready[0]);
        end
        A_VALID = 0;
        for (int i = 0; i < 170; i++) begin
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL fpop_drain dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
            if (wr[0]) got.push_back({addr[0], dataw[0]});
        end
        nvec++;
        if (got != acc) begin
            nmis++;
            $display("FAIL fpop_order got n=%0d want n=%0d", got.size(), acc.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int pulses;
        seen = 0; pulses = 0;
        do_reset();
        A_VALID = 1;
        for (int i = 0; i < 3; i++) begin
            A_ADDR = 5'(i); A_DATA = 8'($urandom);
            B_VALID = (i == 0); B_ADDR = 5'h10; B_DATA = 8'h5A;
            advance();
        end
        A_VALID = 0; B_VALID = 0;
        ck_on = 1;
        for (int i = 0; i < 40 && !seen; i++) begin
            advance();
            if (wr[0]) seen = 1;
        end
        nvec++;
        if (!seen) begin
            nmis++;
            $display("FAIL rmid_timeout got no WR want WR within 40 cycles");
        end
        #1 RST = 1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (wr[k] !== 1'b0 || busy[k] !== 1'b0 || obs(k) !== expv(k)) begin
                nmis++;
                $display("FAIL rmid_async dut%0d got wr=%b busy=%b want 0 0", k, wr[k], busy[k]);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 0;
        for (int i = 0; i < 40; i++) begin
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL rmid_after dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
                if (wr[k]) pulses++;
            end
        end
        nvec++;
        if (pulses != 0 || a_ready[0] !== 1'b1 || b_ready[0] !== 1'b1) begin
            nmis++;
            $display("FAIL rmid_quiet got wr=%0d rdy=%b%b want wr=0 rdy=11", pulses, a_ready[0], b_ready[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        ck_rand = 1;
        for (int i = 0; i < 500; i++) begin
            A_VALID = ($urandom_range(0, 2) == 0);
            B_VALID = ($urandom_range(0, 3) == 0);
            A_ADDR = 5'($urandom); A_DATA = 8'($urandom);
            B_ADDR = 5'($urandom); B_DATA = 8'($urandom);
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL rand dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
        end
        A_VALID = 0; B_VALID = 0;
        ck_rand = 0; ck_on = 1;
        for (int i = 0; i < 320; i++) begin
            advance();
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (obs(k) !== expv(k)) begin
                    nmis++;
                    $display("FAIL rand_drain dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k));
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (busy[k] !== 1'b0) begin
                nmis++;
                $display("FAIL rand_idle dut%0d got busy=%b want 0", k, busy[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gap();
        test_full();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
